// File: rtl/result_display.sv
// result_display: captures read-data beats from two bus masters into
// per-master buffers and lets a user browse them on four 7-segment
// digits with next/prev/select buttons. The view FSM is active only in
// run mode (mode_switch=1). Beats are captured in every view state.
module result_display #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] rdata1,
    input  logic [DATA_LEN-1:0] rdata2,
    input  logic                rvalid1,
    input  logic                rvalid2,
    input  logic                done1,
    input  logic                done2,
    input  logic                clear1,
    input  logic                clear2,
    input  logic                mode_switch,
    input  logic                btn_next,
    input  logic                btn_prev,
    input  logic                btn_sel,
    output logic [3:0]          digit3,
    output logic [3:0]          digit2,
    output logic [3:0]          digit1,
    output logic [3:0]          digit0,
    output logic                led_done,
    output logic                led_ovf
);

    // Count must reach DEPTH itself, so it needs one more value than an address.
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = 4;
    localparam int NUM_M  = 2;

    typedef enum logic [1:0] {
        BLANK      = 2'd0,
        SHOW_COUNT = 2'd1,
        SHOW_DATA  = 2'd2
    } view_state_e;

    // Bit positions of the buttons inside the button history vectors.
    localparam int B_NEXT = 0;
    localparam int B_PREV = 1;
    localparam int B_SEL  = 2;

    // ------------------------------------------------------------------
    // Per-master inputs gathered into arrays so both masters share one
    // generate body. Index 0 is master 1, index 1 is master 2.
    // ------------------------------------------------------------------
    logic [DATA_LEN-1:0] rdata_arr [NUM_M];
    logic [NUM_M-1:0]    rvalid_vec;
    logic [NUM_M-1:0]    done_vec;
    logic [NUM_M-1:0]    clear_vec;

    assign rdata_arr[0] = rdata1;
    assign rdata_arr[1] = rdata2;
    assign rvalid_vec   = {rvalid2, rvalid1};
    assign done_vec     = {done2, done1};
    assign clear_vec    = {clear2, clear1};

    // Per-master state exported from the generate blocks.
    logic [CNT_W-1:0]    count_arr [NUM_M];
    logic [NUM_M-1:0]    done_flag;
    logic [NUM_M-1:0]    ovf_flag;
    logic [DATA_LEN-1:0] rd_word   [NUM_M];

    // View FSM state (declared early: the buffers read at idx_reg).
    view_state_e      state_reg;
    logic             vm_reg;      // 0 = master 1, 1 = master 2
    logic [IDX_W-1:0] idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_master
            logic [DATA_LEN-1:0] mem [DEPTH];
            logic [CNT_W-1:0]    count_reg;
            logic                done_reg;
            logic                ovf_reg;
            logic                buf_full;
            logic                accept;

            assign buf_full = (count_reg == CNT_W'(DEPTH));
            // A clear in the same cycle wins over the beat: the beat is dropped.
            assign accept   = rvalid_vec[gi] && !clear_vec[gi] && !buf_full;

            // Buffer write: no reset needed, entries at or beyond count are never shown.
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[count_reg[ADDR_W-1:0]] <= rdata_arr[gi];
                end
            end

            // Beat count plus sticky done/overflow flags; clear has top priority.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                    done_reg  <= 1'b0;
                    ovf_reg   <= 1'b0;
                end else if (clear_vec[gi]) begin
                    count_reg <= '0;
                    done_reg  <= 1'b0;
                    ovf_reg   <= 1'b0;
                end else begin
                    if (accept) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                    if (rvalid_vec[gi] && buf_full) begin
                        ovf_reg <= 1'b1;
                    end
                    if (done_vec[gi]) begin
                        done_reg <= 1'b1;
                    end
                end
            end

            assign count_arr[gi] = count_reg;
            assign done_flag[gi] = done_reg;
            assign ovf_flag[gi]  = ovf_reg;
            assign rd_word[gi]   = mem[ADDR_W'(idx_reg)];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Button history: one register stage plus the previous sample, so a
    // held button produces exactly one single-cycle edge.
    // ------------------------------------------------------------------
    logic [2:0] btn_now_reg;
    logic [2:0] btn_prev_reg;
    logic [2:0] btn_edge;

    // Sample the buttons and keep the previous sample for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_now_reg  <= '0;
            btn_prev_reg <= '0;
        end else begin
            btn_now_reg  <= {btn_sel, btn_prev, btn_next};
            btn_prev_reg <= btn_now_reg;
        end
    end

    assign btn_edge = btn_now_reg & ~btn_prev_reg;

    logic edge_next;
    logic edge_prev;
    logic edge_sel;

    assign edge_next = btn_edge[B_NEXT];
    assign edge_prev = btn_edge[B_PREV];
    assign edge_sel  = btn_edge[B_SEL];

    // ------------------------------------------------------------------
    // Values of the currently viewed master.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] view_count;
    logic             view_clear;
    logic             view_done;
    logic             view_ovf;
    logic [CNT_W-1:0] view_last;
    logic             idx_at_last;
    logic             idx_at_first;
    logic             step_next;
    logic             step_prev;

    assign view_count   = count_arr[vm_reg];
    assign view_clear   = clear_vec[vm_reg];
    assign view_done    = done_flag[vm_reg];
    assign view_ovf     = ovf_flag[vm_reg];
    assign view_last    = view_count - CNT_W'(1);
    assign idx_at_last  = (CNT_W'(idx_reg) == view_last);
    assign idx_at_first = (idx_reg == '0);
    // Simultaneous next and prev edges cancel each other out.
    assign step_next    = edge_next && !edge_prev;
    assign step_prev    = edge_prev && !edge_next;

    // View FSM: config mode forces BLANK; select beats next/prev; a clear of
    // the viewed master pulls the view back to its (now empty) count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= BLANK;
            vm_reg    <= 1'b0;
            idx_reg   <= '0;
        end else if (!mode_switch) begin
            state_reg <= BLANK;
            vm_reg    <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                BLANK: begin
                    state_reg <= SHOW_COUNT;
                end
                SHOW_COUNT: begin
                    if (edge_sel) begin
                        vm_reg    <= ~vm_reg;
                        idx_reg   <= '0;
                        state_reg <= SHOW_COUNT;
                    end else if ((step_next || step_prev) && !view_clear
                                 && (view_count != '0)) begin
                        idx_reg   <= '0;
                        state_reg <= SHOW_DATA;
                    end
                end
                SHOW_DATA: begin
                    if (edge_sel) begin
                        vm_reg    <= ~vm_reg;
                        idx_reg   <= '0;
                        state_reg <= SHOW_COUNT;
                    end else if (view_clear) begin
                        idx_reg   <= '0;
                        state_reg <= SHOW_COUNT;
                    end else if (step_next) begin
                        if (idx_at_last) begin
                            idx_reg <= '0;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else if (step_prev) begin
                        if (idx_at_first) begin
                            idx_reg <= IDX_W'(view_last);
                        end else begin
                            idx_reg <= idx_reg - IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= BLANK;
                    vm_reg    <= 1'b0;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display formatting, registered one cycle behind the view state.
    // ------------------------------------------------------------------
    logic [3:0] vm_digit;
    logic [7:0] count_byte;
    logic [7:0] data_byte;

    assign vm_digit   = vm_reg ? 4'd2 : 4'd1;
    assign count_byte = 8'(view_count);
    assign data_byte  = 8'(rd_word[vm_reg]);

    // Register the digits and LEDs from the current view state and buffers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit3   <= 4'h0;
            digit2   <= 4'h0;
            digit1   <= 4'h0;
            digit0   <= 4'h0;
            led_done <= 1'b0;
            led_ovf  <= 1'b0;
        end else begin
            case (state_reg)
                SHOW_COUNT: begin
                    digit3   <= vm_digit;
                    digit2   <= 4'hC;
                    digit1   <= count_byte[7:4];
                    digit0   <= count_byte[3:0];
                    led_done <= view_done;
                    led_ovf  <= view_ovf;
                end
                SHOW_DATA: begin
                    digit3   <= vm_digit;
                    digit2   <= idx_reg;
                    digit1   <= data_byte[7:4];
                    digit0   <= data_byte[3:0];
                    led_done <= view_done;
                    led_ovf  <= view_ovf;
                end
                default: begin
                    digit3   <= 4'h0;
                    digit2   <= 4'h0;
                    digit1   <= 4'h0;
                    digit0   <= 4'h0;
                    led_done <= 1'b0;
                    led_ovf  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display: a table of user/bus actions, each followed
// by a settle period and a check of the digits and LEDs, plus a hand-written
// asynchronous reset sequence in the middle of a burst.
module tb_result_display;

    logic       clk;
    logic       reset;
    logic [7:0] rdata1, rdata2;
    logic       rvalid1, rvalid2;
    logic       done1, done2;
    logic       clear1, clear2;
    logic       mode_switch;
    logic       btn_next, btn_prev, btn_sel;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       led_done, led_ovf;

    int checks   = 0;
    int failures = 0;

    result_display #(.DATA_LEN(8), .DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .rvalid1     (rvalid1),
        .rvalid2     (rvalid2),
        .done1       (done1),
        .done2       (done2),
        .clear1      (clear1),
        .clear2      (clear2),
        .mode_switch (mode_switch),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .btn_sel     (btn_sel),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1),
        .digit0      (digit0),
        .led_done    (led_done),
        .led_ovf     (led_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        A_MODE0, A_MODE1, A_BEAT1, A_DONE1, A_NEXT, A_PREV, A_NP, A_HOLDNEXT,
        A_BURST2, A_SEL, A_CLRBEAT1, A_CLEAR2, A_DONEBEAT1, A_SELNEXT
    } act_e;

    typedef struct {
        act_e       act;
        logic [7:0] arg;
        logic [15:0] dig;   // {digit3, digit2, digit1, digit0}
        logic [1:0]  led;   // {led_done, led_ovf}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(act_e a, logic [7:0] arg, logic [15:0] dig, logic [1:0] led);
        vec_t v;
        v.act = a;
        v.arg = arg;
        v.dig = dig;
        v.led = led;
        vecs.push_back(v);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] b, input int len);
        {btn_sel, btn_prev, btn_next} = b;
        cyc(len);
        {btn_sel, btn_prev, btn_next} = 3'b000;
    endtask

    task automatic check(input string name, input logic [15:0] dig, input logic [1:0] led);
        logic [17:0] got;
        logic [17:0] need;
        got  = {digit3, digit2, digit1, digit0, led_done, led_ovf};
        need = {dig, led};
        checks++;
        if (got !== need) begin
            failures++;
            $display("FAIL %s got digits=%h leds=%b need digits=%h leds=%b",
                     name, got[17:2], got[1:0], dig, led);
        end
    endtask

    task automatic apply(input vec_t v);
        case (v.act)
            A_MODE0: begin mode_switch = 1'b0; cyc(1); end
            A_MODE1: begin mode_switch = 1'b1; cyc(1); end
            A_BEAT1: begin
                rvalid1 = 1'b1; rdata1 = v.arg; cyc(1); rvalid1 = 1'b0;
            end
            A_DONE1: begin done1 = 1'b1; cyc(1); done1 = 1'b0; end
            A_NEXT:     press(3'b001, 1);
            A_PREV:     press(3'b010, 1);
            A_NP:       press(3'b011, 1);
            A_HOLDNEXT: press(3'b001, 10);
            A_SEL:      press(3'b100, 1);
            A_SELNEXT:  press(3'b101, 1);
            A_BURST2: begin
                rvalid2 = 1'b1;
                for (int i = 0; i < 17; i++) begin
                    rdata2 = 8'h30 + 8'(i);
                    cyc(1);
                end
                rvalid2 = 1'b0;
            end
            A_CLRBEAT1: begin
                clear1 = 1'b1; rvalid1 = 1'b1; rdata1 = v.arg; cyc(1);
                clear1 = 1'b0; rvalid1 = 1'b0;
            end
            A_CLEAR2: begin clear2 = 1'b1; cyc(1); clear2 = 1'b0; end
            A_DONEBEAT1: begin
                done1 = 1'b1; rvalid1 = 1'b1; rdata1 = v.arg; cyc(1);
                done1 = 1'b0; rvalid1 = 1'b0;
            end
            default: cyc(1);
        endcase
    endtask

    initial begin
        reset = 1'b0; mode_switch = 1'b0;
        rdata1 = '0; rdata2 = '0; rvalid1 = 0; rvalid2 = 0;
        done1 = 0; done2 = 0; clear1 = 0; clear2 = 0;
        btn_next = 0; btn_prev = 0; btn_sel = 0;

        // Expected outputs, hand-derived from the intended behaviour.
        add(A_MODE1,     8'h00, 16'h1C00, 2'b00);
        add(A_BEAT1,     8'hA1, 16'h1C01, 2'b00);
        add(A_BEAT1,     8'hB2, 16'h1C02, 2'b00);
        add(A_BEAT1,     8'hC3, 16'h1C03, 2'b00);
        add(A_DONE1,     8'h00, 16'h1C03, 2'b10);
        add(A_NEXT,      8'h00, 16'h10A1, 2'b10);
        add(A_NEXT,      8'h00, 16'h11B2, 2'b10);
        add(A_NEXT,      8'h00, 16'h12C3, 2'b10);
        add(A_NEXT,      8'h00, 16'h10A1, 2'b10);  // wrap to idx 0
        add(A_PREV,      8'h00, 16'h12C3, 2'b10);  // wrap to count-1
        add(A_NP,        8'h00, 16'h12C3, 2'b10);  // both edges: no change
        add(A_HOLDNEXT,  8'h00, 16'h10A1, 2'b10);  // held: single step
        add(A_BURST2,    8'h00, 16'h10A1, 2'b10);  // other master: view unchanged
        add(A_SEL,       8'h00, 16'h2C10, 2'b01);  // 16 beats kept, ovf set
        add(A_PREV,      8'h00, 16'h2030, 2'b01);
        add(A_PREV,      8'h00, 16'h2F3F, 2'b01);  // idx 15 holds beat 16, not 17
        add(A_NEXT,      8'h00, 16'h2030, 2'b01);
        add(A_MODE0,     8'h00, 16'h0000, 2'b00);
        add(A_MODE1,     8'h00, 16'h1C03, 2'b10);
        add(A_NEXT,      8'h00, 16'h10A1, 2'b10);
        add(A_CLRBEAT1,  8'h55, 16'h1C00, 2'b00);
        add(A_NEXT,      8'h00, 16'h1C00, 2'b00);  // count 0: stay
        add(A_BEAT1,     8'h77, 16'h1C01, 2'b00);
        add(A_NEXT,      8'h00, 16'h1077, 2'b00);
        add(A_CLEAR2,    8'h00, 16'h1077, 2'b00);
        add(A_SEL,       8'h00, 16'h2C00, 2'b00);
        add(A_DONEBEAT1, 8'h88, 16'h2C00, 2'b00);
        add(A_SEL,       8'h00, 16'h1C02, 2'b10);
        add(A_MODE0,     8'h00, 16'h0000, 2'b00);
        add(A_BEAT1,     8'h99, 16'h0000, 2'b00);  // captured while blank
        add(A_MODE1,     8'h00, 16'h1C03, 2'b10);
        add(A_NEXT,      8'h00, 16'h1077, 2'b10);
        add(A_PREV,      8'h00, 16'h1299, 2'b10);
        add(A_SELNEXT,   8'h00, 16'h2C00, 2'b00);  // select beats next

        // Power-on reset.
        #1 reset = 1'b1;
        #1 check("reset_state", 16'h0000, 2'b00);
        cyc(3);
        reset = 1'b0;
        cyc(3);
        check("blank_config", 16'h0000, 2'b00);
        $display("reset released, blank in config mode");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            cyc(4);
            check($sformatf("vec%0d_%s", i, vecs[i].act.name()), vecs[i].dig, vecs[i].led);
            $display("vec %0d %s arg=%h digits=%h%h%h%h leds=%b%b", i, vecs[i].act.name(),
                     vecs[i].arg, digit3, digit2, digit1, digit0, led_done, led_ovf);
        end

        // Reset in the middle of a master-1 burst, between clock edges.
        rvalid1 = 1'b1; rdata1 = 8'hD0;
        cyc(2);
        #2 reset = 1'b1;
        #1 check("async_reset_no_edge", 16'h0000, 2'b00);
        $display("async reset mid-burst");
        cyc(1);
        check("reset_held", 16'h0000, 2'b00);
        rvalid1 = 1'b0; reset = 1'b0;
        cyc(4);
        check("post_reset_count", 16'h1C00, 2'b00);
        rvalid1 = 1'b1; rdata1 = 8'hE5; cyc(1); rvalid1 = 1'b0;
        cyc(4);
        check("post_reset_beat", 16'h1C01, 2'b00);
        press(3'b001, 1);
        cyc(4);
        check("post_reset_idx0", 16'h10E5, 2'b00);
        $display("post-reset beat lands at index 0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
